// File: rtl/fmulsu_arbiter.sv
// -----------------------------------------------------------------------------
// fmulsu_arbiter
//
// Two-requester arbiter and sequencer for one shared signed x unsigned
// fractional multiplier (FMULSU: signed Rd times unsigned Rr, product shifted
// left by one, returned as a high and a low byte).
//
// Requesters present an operand pair on a valid/ack handshake. While the
// block is idle it grants one requester (round-robin when both are valid),
// captures that requester's operands and runs the multiply for P_MUL_LAT
// execute cycles. It then holds the tagged result on o_res_* until the
// consumer takes it with i_res_ready.
//
// Parameters
//   P_MUL_LAT     execute cycles per operation, legal range 1..15
//
// Ports
//   i_clk         clock, all state changes on the rising edge
//   i_rst         asynchronous active-high reset
//   i_req0_valid  requester 0 has an operand pair
//   i_req0_rd     requester 0 multiplicand (signed)
//   i_req0_rr     requester 0 multiplier (unsigned)
//   o_req0_ack    requester 0 operands accepted this cycle (combinational)
//   i_req1_*      same as requester 0, for requester 1
//   o_req1_ack    requester 1 operands accepted this cycle (combinational)
//   o_res_valid   result available (registered)
//   o_res_id      requester that owns the result
//   o_res_r1      result high byte
//   o_res_r0      result low byte
//   i_res_ready   consumer accepts the result
//   o_busy        high whenever the sequencer is not idle (registered)
//
// Latency: ack in cycle T, execute in T+1..T+P_MUL_LAT, o_res_valid first
// high in cycle T+P_MUL_LAT+1. With i_res_ready already high the next ack can
// come P_MUL_LAT+2 cycles after the previous one.
// -----------------------------------------------------------------------------
module fmulsu_arbiter #(
  parameter int unsigned P_MUL_LAT = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,

  input  logic       i_req0_valid,
  input  logic [7:0] i_req0_rd,
  input  logic [7:0] i_req0_rr,
  output logic       o_req0_ack,

  input  logic       i_req1_valid,
  input  logic [7:0] i_req1_rd,
  input  logic [7:0] i_req1_rr,
  output logic       o_req1_ack,

  output logic       o_res_valid,
  output logic       o_res_id,
  output logic [7:0] o_res_r1,
  output logic [7:0] o_res_r0,
  input  logic       i_res_ready,

  output logic       o_busy
);

  // ---------------------------------------------------------------------------
  // Types and constants
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter value loaded on grant; EXEC ends in the cycle the counter reads 0,
  // which gives exactly P_MUL_LAT execute cycles.
  localparam logic [3:0] CNT_LOAD = 4'(P_MUL_LAT - 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e     state_q,     state_d;
  logic       ptr_q,       ptr_d;        // requester favoured on a tie
  logic [3:0] cnt_q,       cnt_d;        // execute cycles remaining
  logic [7:0] rd_q,        rd_d;         // captured multiplicand
  logic [7:0] rr_q,        rr_d;         // captured multiplier
  logic       req_id_q,    req_id_d;     // owner of the operation in flight
  logic       res_valid_q, res_valid_d;
  logic       res_id_q,    res_id_d;
  logic [7:0] res_r1_q,    res_r1_d;
  logic [7:0] res_r0_q,    res_r0_d;
  logic       busy_q,      busy_d;

  logic       gnt0;
  logic       gnt1;
  logic [14:0] prod;

  // ---------------------------------------------------------------------------
  // Grant
  //
  // Acks are only given while idle. They are also held off while reset is
  // asserted, so a request is never acknowledged into an operation that the
  // reset is about to throw away.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (state_q == ST_IDLE && !i_rst) begin
      if (i_req0_valid && i_req1_valid) begin
        gnt0 = ~ptr_q;
        gnt1 =  ptr_q;
      end else begin
        gnt0 = i_req0_valid;
        gnt1 = i_req1_valid;
      end
    end
  end

  assign o_req0_ack = gnt0;
  assign o_req1_ack = gnt1;

  // ---------------------------------------------------------------------------
  // Multiplier
  //
  // Only bits [14:0] of the 16-bit signed product survive the left shift, so
  // the multiply is done modulo 2^15: Rd sign-extended and Rr zero-extended to
  // 15 bits give exactly the low 15 bits of the true signed product, including
  // Rd = -128.
  // ---------------------------------------------------------------------------
  assign prod = {{7{rd_q[7]}}, rd_q} * {7'b000_0000, rr_q};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rd_d        = rd_q;
    rr_d        = rr_q;
    req_id_d    = req_id_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    res_r1_d    = res_r1_q;
    res_r0_d    = res_r0_q;

    case (state_q)
      ST_IDLE: begin
        if (gnt0 || gnt1) begin
          rd_d     = gnt1 ? i_req1_rd : i_req0_rd;
          rr_d     = gnt1 ? i_req1_rr : i_req0_rr;
          req_id_d = gnt1;
          cnt_d    = CNT_LOAD;
          // The pointer always moves to the requester that lost this round,
          // whether or not it was actually competing.
          ptr_d    = gnt0;
          state_d  = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          res_r1_d    = prod[14:7];
          res_r0_d    = {prod[6:0], 1'b0};
          res_id_d    = req_id_q;
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_DONE: begin
        // Result data stays put; only the valid flag drops on hand-off.
        if (i_res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
      end
    endcase

    // Registered busy tracks the state being entered, so it lines up with
    // the state register itself.
    busy_d = (state_d != ST_IDLE);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      cnt_q       <= 4'd0;
      rd_q        <= 8'h00;
      rr_q        <= 8'h00;
      req_id_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      res_r1_q    <= 8'h00;
      res_r0_q    <= 8'h00;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rd_q        <= rd_d;
      rr_q        <= rr_d;
      req_id_q    <= req_id_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_r1_q    <= res_r1_d;
      res_r0_q    <= res_r0_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_res_valid = res_valid_q;
  assign o_res_id    = res_id_q;
  assign o_res_r1    = res_r1_q;
  assign o_res_r0    = res_r0_q;
  assign o_busy      = busy_q;

  // ---------------------------------------------------------------------------
  // Protocol properties
  // ---------------------------------------------------------------------------
  // At most one requester is acknowledged in any cycle.
  a_ack_onehot: assert property (@(posedge i_clk) disable iff (i_rst)
    !(o_req0_ack && o_req1_ack));

  // Acks only while the sequencer is idle.
  a_ack_idle_only: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_req0_ack || o_req1_ack) |-> !o_busy);

  // A result that is not taken stays valid and unchanged.
  a_res_hold: assert property (@(posedge i_clk) disable iff (i_rst)
    (o_res_valid && !i_res_ready) |=>
      (o_res_valid && $stable(o_res_r1) && $stable(o_res_r0) && $stable(o_res_id)));

endmodule

// File: doc/fmulsu_arbiter.md
# fmulsu_arbiter

Two-requester arbiter and sequencer for a shared signed×unsigned fractional multiplier (FMULSU semantics: signed Rd × unsigned Rr, result left-shifted by one, split into high/low bytes). It accepts operand pairs from two independent requesters over valid/ack handshakes and grants the multiplier round-robin. It runs the multiply over a configurable number of execute cycles, then holds the tagged result until the consumer accepts it. It sits between the ALU issue logic and the multiplier datapath, so one multiplier can serve two issue paths.

## Interface
- P_MUL_LAT, default 1: execute cycles per operation, legal range 1..15.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_req0_valid  in  1  requester 0 has an operand pair.
- i_req0_rd  in  8  requester 0 multiplicand, signed.
- i_req0_rr  in  8  requester 0 multiplier, unsigned.
- o_req0_ack  out  1  requester 0 operands accepted this cycle.
- i_req1_valid, i_req1_rd, i_req1_rr, o_req1_ack: same as requester 0, for requester 1.
- o_res_valid  out  1  result available.
- o_res_id  out  1  requester that owns the result.
- o_res_r1  out  8  result high byte.
- o_res_r0  out  8  result low byte.
- i_res_ready  in  1  consumer accepts the result.
- o_busy  out  1  asserted whenever state is not IDLE.

## Operation
- States are IDLE, EXEC and DONE.
- IDLE:
  - If any valid is high, grant one requester and pulse its ack (combinational, IDLE only).
  - On the same edge, capture rd, rr and the id, load the execute counter with P_MUL_LAT-1, and go to EXEC.
  - With no valid, stay in IDLE.
- Grant rules:
  - Only one requester valid: grant that requester.
  - Both valid: grant the requester named by the priority pointer.
  - After any grant, the pointer moves to the requester that was not granted.
  - A requester holds valid and operands stable until its ack. Valid dropping before ack withdraws the request; this is legal.
- EXEC:
  - Decrement the counter each cycle.
  - When the counter is 0, register the product into o_res_r1/o_res_r0 and go to DONE.
- Product:
  - p = signed 16-bit value of sign-extended rd × zero-extended rr.
  - o_res_r1 = p[14:7]; o_res_r0 = {p[6:0], 1'b0}.
  - rd = 0x80 (−128) is an exact product, with no special-casing.
- DONE:
  - o_res_valid = 1; o_res_id, r1 and r0 are held stable.
  - When i_res_ready is high, the handshake completes on that edge and the state goes to IDLE.
  - No new grant occurs in the DONE cycle itself.
- Acks are never asserted in EXEC or DONE. Requests wait, with no queueing.
- Reset values: state IDLE, pointer → requester 0, o_res_valid 0, o_res_id 0, o_res_r1 0x00, o_res_r0 0x00, counter 0, o_busy 0, both acks 0.
- Reset mid-operation: any in-flight operation or held result is discarded. The requester is not re-acked and must not re-send.

## Timing
- Ack in cycle T (IDLE) → EXEC in cycles T+1 .. T+P_MUL_LAT → o_res_valid first high at cycle T+P_MUL_LAT+1.
- Latency is P_MUL_LAT+1 cycles from ack to result valid.
- If i_res_ready is already high when o_res_valid rises, the result is consumed after one DONE cycle. The next ack can then come in the following IDLE cycle.
- Minimum issue interval is P_MUL_LAT+2 cycles.
- o_busy is registered: high from T+1 until the edge that enters IDLE.
- Backpressure: DONE lasts for any number of cycles, with outputs unchanged.

## Test plan
- Reset, then requester 0 alone with rd=0x40, rr=0x80 (P_MUL_LAT=1) → ack0 in cycle 0, result valid in cycle 2 with id=0, r1=0x40, r0=0x00.
- Requester 1 alone with rd=0xFF, rr=0xFF → id=1, r1=0xFE, r0=0x02. With rd=0x80, rr=0x02 → r1=0xFE, r0=0x00.
- Both requesters valid continuously, i_res_ready tied high:
  - Grants alternate 0,1,0,1; ack spacing is exactly P_MUL_LAT+2 cycles.
  - No ack is seen during EXEC or DONE.
- i_res_ready held low for 5 cycles in DONE → o_res_valid and the data stay stable for all 5 cycles, and no ack is issued. On release, the state returns to IDLE.
- i_rst asserted asynchronously mid-EXEC → all outputs go to reset values immediately, with no result emitted. The next grant with both requesters valid goes to requester 0.
- P_MUL_LAT=4, rd=0x7F, rr=0xFF → result valid 5 cycles after ack with r1=0xFD, r0=0x02.
